// File: rtl/sd_disk_arbiter.sv
// rtl/sd_disk_arbiter.sv - round-robin arbiter sharing one host SD block channel among disk images
module sd_disk_arbiter #(
   parameter int          NUM_DISKS = 4,
   parameter logic [15:0] TIMEOUT   = 16'd50000
) (
   input  logic                   clk_sys,
   input  logic                   reset_n,
   input  logic [NUM_DISKS-1:0]   req_rd,
   input  logic [NUM_DISKS-1:0]   req_wr,
   input  logic [32*NUM_DISKS-1:0] req_lba,
   input  logic [8*NUM_DISKS-1:0] req_din,
   output logic [NUM_DISKS-1:0]   req_ack,
   input  logic [NUM_DISKS-1:0]   img_mounted,
   output logic [NUM_DISKS-1:0]   host_rd,
   output logic [NUM_DISKS-1:0]   host_wr,
   output logic [31:0]            host_lba,
   input  logic                   host_ack,
   output logic [7:0]             host_din,
   output logic                   timeout_err
);

   localparam int GW = (NUM_DISKS > 1) ? $clog2(NUM_DISKS) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_XFER  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                r_state;
   logic [GW-1:0]         r_grant;
   logic [GW-1:0]         r_last_grant;
   logic                  r_op_wr;
   logic [15:0]           r_cnt;
   logic [NUM_DISKS-1:0]  r_strobe;
   logic [31:0]           r_host_lba;
   logic                  r_timeout_err;

   logic [NUM_DISKS-1:0]  w_req;
   logic                  w_pick_valid;
   logic [GW-1:0]         w_pick;
   logic [NUM_DISKS-1:0]  w_pick_oh;
   logic [31:0]           w_pick_lba;
   int                    w_dist;
   int                    w_best;

   assign w_req = req_rd | req_wr;

   // Round-robin pick: the requester closest after last_grant wins (distance 0 = last_grant+1).
   always_comb begin
      w_pick_valid = (w_req != '0);
      w_pick       = '0;
      w_best       = NUM_DISKS;
      w_dist       = 0;
      for (int i = 0; i < NUM_DISKS; i++) begin
         w_dist = (i + NUM_DISKS - 1 - int'(r_last_grant)) % NUM_DISKS;
         if (w_req[i] && (w_dist < w_best)) begin
            w_best = w_dist;
            w_pick = GW'(i);
         end
      end
   end

   // One-hot and LBA of the picked requester.
   always_comb begin
      w_pick_oh  = '0;
      w_pick_lba = 32'h0;
      for (int i = 0; i < NUM_DISKS; i++) begin
         if (GW'(i) == w_pick) begin
            w_pick_oh[i] = 1'b1;
            w_pick_lba   = req_lba[32*i +: 32];
         end
      end
   end

   // Arbitration FSM; grant, LBA and op type are captured once and held until IDLE.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= S_IDLE;
         r_grant       <= '0;
         r_last_grant  <= GW'(NUM_DISKS - 1);
         r_op_wr       <= 1'b0;
         r_cnt         <= 16'h0;
         r_strobe      <= '0;
         r_host_lba    <= 32'h0;
         r_timeout_err <= 1'b0;
      end else begin
         r_timeout_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_pick_valid) begin
                  r_grant    <= w_pick;
                  r_host_lba <= w_pick_lba;
                  r_op_wr    <= ~req_rd[w_pick];
                  r_cnt      <= 16'h0;
                  r_strobe   <= w_pick_oh;
                  r_state    <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_cnt <= r_cnt + 16'd1;
               if (host_ack) begin
                  r_strobe <= '0;
                  r_state  <= S_XFER;
               end else if (img_mounted[r_grant]) begin
                  r_strobe <= '0;
                  r_state  <= S_DONE;
               end else if (r_cnt == TIMEOUT - 16'd1) begin
                  r_strobe      <= '0;
                  r_timeout_err <= 1'b1;
                  r_state       <= S_DONE;
               end
            end
            S_XFER: begin
               if (!host_ack) begin
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_last_grant <= r_grant;
               r_state      <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Ack routing and write-data mux follow the held grant; state gating makes reset clear them at once.
   always_comb begin
      req_ack  = '0;
      host_din = 8'h00;
      for (int i = 0; i < NUM_DISKS; i++) begin
         if (GW'(i) == r_grant) begin
            if ((r_state == S_ISSUE) || (r_state == S_XFER)) begin
               req_ack[i] = host_ack;
            end
            if (r_state != S_IDLE) begin
               host_din = req_din[8*i +: 8];
            end
         end
      end
   end

   assign host_rd     = r_strobe & {NUM_DISKS{~r_op_wr}};
   assign host_wr     = r_strobe & {NUM_DISKS{r_op_wr}};
   assign host_lba    = r_host_lba;
   assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_sd_disk_arbiter.sv
// tb/tb_sd_disk_arbiter.sv - scoreboard bench for sd_disk_arbiter
module tb_sd_disk_arbiter;

   localparam int          NUM = 4;
   localparam logic [15:0] TMO = 16'd100;

   typedef struct {
      int          disk;
      bit          wr;
      logic [31:0] lba;
      logic [7:0]  din;
   } exp_t;

   logic            clk_sys = 1'b0;
   logic            reset_n = 1'b0;
   logic [NUM-1:0]  req_rd = '0;
   logic [NUM-1:0]  req_wr = '0;
   logic [NUM-1:0]  img_mounted = '0;
   logic            host_ack = 1'b0;
   logic [31:0]     lba_arr [NUM];
   logic [7:0]      din_arr [NUM];
   wire  [32*NUM-1:0] req_lba = {lba_arr[3], lba_arr[2], lba_arr[1], lba_arr[0]};
   wire  [8*NUM-1:0]  req_din = {din_arr[3], din_arr[2], din_arr[1], din_arr[0]};
   logic [NUM-1:0]  req_ack;
   logic [NUM-1:0]  host_rd;
   logic [NUM-1:0]  host_wr;
   logic [31:0]     host_lba;
   logic [7:0]      host_din;
   logic            timeout_err;

   int   errors = 0;
   int   checks = 0;
   int   grant_count = 0;
   int   m_last = NUM - 1;
   bit   host_mode = 1'b0;
   bit   auto_drop = 1'b1;
   exp_t exp_q[$];

   sd_disk_arbiter #(.NUM_DISKS(NUM), .TIMEOUT(TMO)) dut (
      .clk_sys     (clk_sys),
      .reset_n     (reset_n),
      .req_rd      (req_rd),
      .req_wr      (req_wr),
      .req_lba     (req_lba),
      .req_din     (req_din),
      .req_ack     (req_ack),
      .img_mounted (img_mounted),
      .host_rd     (host_rd),
      .host_wr     (host_wr),
      .host_lba    (host_lba),
      .host_ack    (host_ack),
      .host_din    (host_din),
      .timeout_err (timeout_err)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: round-robin from the last grant, read before write on the same disk.
   task automatic push_model(input logic [NUM-1:0] rd_in, input logic [NUM-1:0] wr_in,
                             input int max_grants, input bit consume);
      logic [NUM-1:0] rd;
      logic [NUM-1:0] wr;
      int n;
      int d;
      exp_t e;
      rd = rd_in;
      wr = wr_in;
      n  = 0;
      while (n < max_grants && (rd | wr) != '0) begin
         for (int k = 1; k <= NUM; k++) begin
            d = (m_last + k) % NUM;
            if (rd[d] || wr[d]) begin
               e.disk = d;
               e.wr   = !rd[d];
               e.lba  = lba_arr[d];
               e.din  = din_arr[d];
               exp_q.push_back(e);
               if (consume) begin
                  if (rd[d]) rd[d] = 1'b0;
                  else       wr[d] = 1'b0;
               end
               m_last = d;
               n++;
               break;
            end
         end
      end
   endtask

   task automatic wait_strobe(input logic [NUM-1:0] mask);
      bit ok;
      ok = 1'b0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk_sys);
         if (((host_rd | host_wr) & mask) != '0) begin
            ok = 1'b1;
            break;
         end
      end
      chk("strobe_wait", 32'(ok), 32'd1);
   endtask

   task automatic wait_idle(input string tag);
      int quiet;
      bit done;
      quiet = 0;
      done  = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk_sys);
         if ((req_rd | req_wr) == '0 && (host_rd | host_wr) == '0 && !host_ack && exp_q.size() == 0)
            quiet++;
         else
            quiet = 0;
         if (quiet >= 4) begin
            done = 1'b1;
            break;
         end
      end
      chk({tag, "_drain"}, 32'(done), 32'd1);
      if (!done) begin
         exp_q.delete();
         req_rd = '0;
         req_wr = '0;
      end
   endtask

   // Monitor: every new host strobe is a grant and is checked against the scoreboard head.
   logic [NUM-1:0] m_prev = '0;
   logic [NUM-1:0] m_oh;
   exp_t           m_e;
   always @(negedge clk_sys) begin
      if (reset_n && (host_rd | host_wr) != '0 && m_prev == '0) begin
         grant_count++;
         if (exp_q.size() == 0) begin
            chk("unexpected_grant", 32'(host_rd | host_wr), 32'd0);
         end else begin
            m_e  = exp_q.pop_front();
            m_oh = 4'b0001 << m_e.disk;
            chk("grant_rd", 32'(host_rd), m_e.wr ? 32'd0 : 32'(m_oh));
            chk("grant_wr", 32'(host_wr), m_e.wr ? 32'(m_oh) : 32'd0);
            chk("grant_lba", host_lba, m_e.lba);
            chk("grant_din", 32'(host_din), 32'(m_e.din));
         end
      end
      m_prev = host_rd | host_wr;
   end

   // Disk side: a request is retired when its ack rises (read first if both pending).
   logic [NUM-1:0] d_prev = '0;
   always @(negedge clk_sys) begin
      for (int i = 0; i < NUM; i++) begin
         if (auto_drop && req_ack[i] && !d_prev[i]) begin
            if (req_rd[i]) req_rd[i] = 1'b0;
            else           req_wr[i] = 1'b0;
         end
      end
      d_prev = req_ack;
   end

   // Host side: answers strobes with a random ack delay and length.
   initial begin
      int dly;
      int len;
      forever begin
         @(negedge clk_sys);
         if (host_mode == 1'b0 && (host_rd | host_wr) != '0) begin
            dly = $urandom_range(0, 5);
            repeat (dly) @(negedge clk_sys);
            host_ack = 1'b1;
            len = $urandom_range(1, 4);
            repeat (len) @(negedge clk_sys);
            host_ack = 1'b0;
         end
      end
   end

   initial begin
      repeat (50000) @(posedge clk_sys);
      errors++;
      $display("FAIL watchdog: got no finish expected finish");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int hi;
      int drop_at;
      int to_at;
      int to_cnt;
      logic [NUM-1:0] r;
      logic [NUM-1:0] w;

      for (int i = 0; i < NUM; i++) begin
         lba_arr[i] = 32'h100 * (i + 1);
         din_arr[i] = 8'(8'h10 + i);
      end

      // reset state with requests and ack active
      host_mode = 1'b1;
      req_rd    = 4'b1111;
      host_ack  = 1'b1;
      repeat (3) @(posedge clk_sys);
      #1;
      chk("rst_host_rd", 32'(host_rd), 32'd0);
      chk("rst_host_wr", 32'(host_wr), 32'd0);
      chk("rst_req_ack", 32'(req_ack), 32'd0);
      chk("rst_host_lba", host_lba, 32'd0);
      chk("rst_host_din", 32'(host_din), 32'd0);
      chk("rst_timeout", 32'(timeout_err), 32'd0);
      @(negedge clk_sys);
      req_rd   = '0;
      host_ack = 1'b0;
      reset_n  = 1'b1;

      // a request withdrawn before the sampling edge is never granted
      @(negedge clk_sys);
      req_rd[1] = 1'b1;
      #2 req_rd[1] = 1'b0;
      repeat (4) @(negedge clk_sys);
      chk("glitch_no_grant", 32'(host_rd | host_wr), 32'd0);

      // round robin with requests held on disks 0,1,3
      host_mode = 1'b0;
      auto_drop = 1'b0;
      @(negedge clk_sys);
      req_rd = 4'b1011;
      push_model(4'b1011, 4'b0000, 4, 1'b0);
      begin
         int g0;
         bit ok;
         g0 = grant_count;
         ok = 1'b0;
         for (int c = 0; c < 500; c++) begin
            @(negedge clk_sys);
            if (grant_count >= g0 + 4) begin
               ok = 1'b1;
               break;
            end
         end
         chk("rr_four_grants", 32'(ok), 32'd1);
      end
      req_rd    = '0;
      auto_drop = 1'b1;
      wait_idle("rr");

      // single read on disk 2: latency, LBA and ack mirroring
      host_mode = 1'b1;
      @(negedge clk_sys);
      lba_arr[2] = 32'h1234;
      din_arr[2] = 8'h5a;
      req_rd     = 4'b0100;
      push_model(4'b0100, 4'b0000, 1, 1'b1);
      chk("lat_before", 32'(host_rd), 32'd0);
      @(posedge clk_sys);
      @(posedge clk_sys);
      #1;
      chk("lat_rd", 32'(host_rd), 32'b0100);
      chk("lat_lba", host_lba, 32'h1234);
      chk("lat_din", 32'(host_din), 32'h5a);
      @(negedge clk_sys);
      host_ack = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1 chk("ack_mirror", 32'(req_ack), 32'b0100);
         @(negedge clk_sys);
      end
      host_ack = 1'b0;
      #1 chk("ack_drop", 32'(req_ack), 32'd0);
      @(posedge clk_sys);
      #1 chk("done_no_strobe", 32'(host_rd | host_wr), 32'd0);
      wait_idle("single");

      // host_ack in IDLE is ignored
      @(negedge clk_sys);
      host_ack = 1'b1;
      #1 chk("idle_ack", 32'(req_ack), 32'd0);
      @(negedge clk_sys);
      chk("idle_ack_hold", 32'(req_ack | host_rd | host_wr), 32'd0);
      host_ack = 1'b0;

      // read and write together on disk 1: read first, then write
      host_mode = 1'b0;
      @(negedge clk_sys);
      lba_arr[1] = 32'hbeef_0001;
      req_rd = 4'b0010;
      req_wr = 4'b0010;
      push_model(4'b0010, 4'b0010, 10, 1'b1);
      wait_idle("rdwr");

      // timeout: host never acks disk 0
      host_mode = 1'b1;
      @(negedge clk_sys);
      req_rd = 4'b0001;
      push_model(4'b0001, 4'b0000, 1, 1'b1);
      wait_strobe(4'b0001);
      hi = 1; drop_at = -1; to_at = -1; to_cnt = 0;
      for (int c = 1; c < 300; c++) begin
         @(negedge clk_sys);
         if (host_rd[0]) hi++;
         else if (drop_at < 0) drop_at = c;
         if (timeout_err) begin
            to_cnt++;
            if (to_at < 0) to_at = c;
            req_rd[0] = 1'b0;
         end
      end
      chk("to_issue_cycles", 32'(hi), 32'd100);
      chk("to_pulse_count", 32'(to_cnt), 32'd1);
      chk("to_pulse_at_drop", 32'(to_at), 32'(drop_at));
      wait_idle("timeout");

      // mount change on disk 3 during ISSUE aborts; other disks' pulses do not
      @(negedge clk_sys);
      lba_arr[3] = 32'h0003_3333;
      req_rd = 4'b1000;
      push_model(4'b1000, 4'b0000, 1, 1'b1);
      wait_strobe(4'b1000);
      img_mounted = 4'b0010;
      @(negedge clk_sys);
      img_mounted = 4'b0000;
      chk("mount_other_ignored", 32'(host_rd), 32'b1000);
      img_mounted = 4'b1000;
      @(negedge clk_sys);
      img_mounted = 4'b0000;
      req_rd[3]   = 1'b0;
      chk("mount_abort_strobe", 32'(host_rd), 32'd0);
      host_ack = 1'b1;
      #1 chk("mount_abort_no_ack", 32'(req_ack), 32'd0);
      @(negedge clk_sys);
      host_ack = 1'b0;
      wait_idle("abort");

      // the same pulse during XFER is ignored
      @(negedge clk_sys);
      req_rd = 4'b1000;
      push_model(4'b1000, 4'b0000, 1, 1'b1);
      wait_strobe(4'b1000);
      host_ack = 1'b1;
      @(negedge clk_sys);
      img_mounted = 4'b1000;
      @(negedge clk_sys);
      img_mounted = 4'b0000;
      for (int c = 0; c < 2; c++) begin
         chk("xfer_mount_ack", 32'(req_ack), 32'b1000);
         @(negedge clk_sys);
      end
      host_ack = 1'b0;
      chk("xfer_mount_no_to", 32'(timeout_err), 32'd0);
      wait_idle("xfer_mount");

      // randomized batches
      host_mode = 1'b0;
      for (int b = 0; b < 12; b++) begin
         @(negedge clk_sys);
         r = 4'($urandom_range(0, 15));
         w = 4'($urandom_range(0, 15));
         if ((r | w) == '0) r = 4'b0001;
         for (int i = 0; i < NUM; i++) begin
            lba_arr[i] = $urandom;
            din_arr[i] = 8'($urandom);
         end
         req_rd = r;
         req_wr = w;
         push_model(r, w, 100, 1'b1);
         wait_idle("rand");
      end

      // reset during XFER, then pending write on disk 0 must win
      @(negedge clk_sys);
      req_rd = 4'b0001;
      push_model(4'b0001, 4'b0000, 1, 1'b1);
      wait_idle("pre_reset");
      host_mode = 1'b1;
      @(negedge clk_sys);
      lba_arr[0] = 32'h0000_0a00;
      req_rd = 4'b0100;
      push_model(4'b0100, 4'b0000, 1, 1'b1);
      wait_strobe(4'b0100);
      req_wr[0] = 1'b1;
      req_rd[1] = 1'b1;
      host_ack  = 1'b1;
      @(negedge clk_sys);
      chk("pre_reset_ack", 32'(req_ack), 32'b0100);
      reset_n = 1'b0;
      #1;
      chk("arst_host_rd", 32'(host_rd), 32'd0);
      chk("arst_host_wr", 32'(host_wr), 32'd0);
      chk("arst_req_ack", 32'(req_ack), 32'd0);
      chk("arst_host_lba", host_lba, 32'd0);
      chk("arst_host_din", 32'(host_din), 32'd0);
      @(negedge clk_sys);
      host_ack = 1'b0;
      req_rd   = 4'b0010;
      req_wr   = 4'b0001;
      @(negedge clk_sys);
      m_last    = NUM - 1;
      reset_n   = 1'b1;
      host_mode = 1'b0;
      push_model(4'b0010, 4'b0001, 10, 1'b1);
      wait_idle("post_reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
